// File: rtl/uart_sample_rx.sv
// 8N1 UART receiver that pairs consecutive bytes little-endian into 16-bit mono samples.
// A lone low byte is dropped after a configurable idle gap so the byte pairing resynchronises.
module uart_sample_rx #(
  parameter int CLKS_PER_BIT = 234,
  parameter int GAP_TIMEOUT  = 2808
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx,
  output logic [15:0] data_out,
  output logic        sample_valid,
  output logic        frame_err,
  output logic        busy
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  localparam int         GW       = $clog2(GAP_TIMEOUT + 1);
  localparam logic [15:0] HALF_CNT = 16'(CLKS_PER_BIT / 2 - 1);
  localparam logic [15:0] BIT_CNT  = 16'(CLKS_PER_BIT - 1);
  localparam logic [GW-1:0] GAP_END = GW'(GAP_TIMEOUT);

  logic          rx_meta;
  logic          rxs;
  logic [1:0]    state;
  logic [15:0]   cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic [7:0]    low_byte;
  logic          pending;
  logic [GW-1:0] gap_cnt;

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta      <= 1'b1;
      rxs          <= 1'b1;
      state        <= IDLE;
      cnt          <= '0;
      bit_idx      <= '0;
      shreg        <= '0;
      low_byte     <= '0;
      pending      <= 1'b0;
      gap_cnt      <= '0;
      data_out     <= '0;
      sample_valid <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      rx_meta      <= rx;
      rxs          <= rx_meta;
      sample_valid <= 1'b0;
      frame_err    <= 1'b0;

      // Orphaned low byte: give up on it after a long idle so pairing realigns
      if (state == IDLE && pending) begin
        if (gap_cnt == GAP_END) begin
          pending <= 1'b0;
          gap_cnt <= '0;
        end else begin
          gap_cnt <= gap_cnt + GW'(1);
        end
      end else begin
        gap_cnt <= '0;
      end

      case (state)
        IDLE: begin
          if (!rxs) begin
            state <= START;
            cnt   <= HALF_CNT;
          end
        end
        START: begin
          if (cnt == 16'd0) begin
            if (!rxs) begin
              state   <= DATA;
              cnt     <= BIT_CNT;
              bit_idx <= 3'd0;
            end else begin
              state <= IDLE;
            end
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
        DATA: begin
          if (cnt == 16'd0) begin
            shreg   <= {rxs, shreg[7:1]};
            cnt     <= BIT_CNT;
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) state <= STOP;
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
        default: begin
          // STOP: sample mid stop bit and drop to IDLE so a following start bit is not missed
          if (cnt == 16'd0) begin
            state <= IDLE;
            if (rxs) begin
              if (pending) begin
                data_out     <= {shreg, low_byte};
                sample_valid <= 1'b1;
                pending      <= 1'b0;
              end else begin
                low_byte <= shreg;
                pending  <= 1'b1;
              end
            end else begin
              frame_err <= 1'b1;
              pending   <= 1'b0;
            end
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_sample_rx.sv
// Directed bench for uart_sample_rx: serial stimulus with a sample scoreboard
// checked on the falling edge whenever the receiver strobes.
module tb_uart_sample_rx;

  localparam int CPB = 16;
  localparam int GAP = 200;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx  = 1'b1;
  logic [15:0] data_out;
  logic        sample_valid;
  logic        frame_err;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;
  int n_sv = 0;
  int n_fe = 0;
  int cyc = 0;
  int last_sv_cyc = -1;
  logic prev_sv = 1'b0;
  logic [15:0] exp_q[$];

  uart_sample_rx #(.CLKS_PER_BIT(CPB), .GAP_TIMEOUT(GAP)) dut (
    .clk(clk), .rst(rst), .rx(rx), .data_out(data_out),
    .sample_valid(sample_valid), .frame_err(frame_err), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop_bit;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic send_sample(input logic [15:0] s);
    exp_q.push_back(s);
    send_byte(s[7:0], 1'b1);
    send_byte(s[15:8], 1'b1);
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int c0;
    int sv0;
    int fe0;
    logic [15:0] r;

    fork
      forever begin
        @(negedge clk);
        if (sample_valid) begin
          chk("sv_not_consecutive", 32'(prev_sv), 32'd0);
          chk("sv_fe_exclusive", 32'(frame_err), 32'd0);
          chk("strobe_expected", 32'(exp_q.size() > 0), 32'd1);
          if (exp_q.size() > 0) chk("sample", 32'(data_out), 32'(exp_q.pop_front()));
          n_sv++;
          last_sv_cyc = cyc;
        end
        if (frame_err) n_fe++;
        prev_sv = sample_valid;
      end
    join_none

    // Reset state
    repeat (5) @(negedge clk);
    chk("rst_data_out", 32'(data_out), 32'd0);
    chk("rst_sample_valid", 32'(sample_valid), 32'd0);
    chk("rst_frame_err", 32'(frame_err), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    idle(3 * CPB);

    // 0x34 then 0x12, with strobe timing relative to the 2nd start bit
    exp_q.push_back(16'h1234);
    send_byte(8'h34, 1'b1);
    c0 = cyc;
    send_byte(8'h12, 1'b1);
    idle(2 * CPB);
    chk("basic_count", 32'(n_sv), 32'd1);
    chk("basic_latency", 32'(last_sv_cyc), 32'(c0 + 3 + CPB / 2 + 9 * CPB));
    chk("basic_hold", 32'(data_out), 32'h1234);

    // Start-bit glitch shorter than half a bit
    sv0 = n_sv;
    fe0 = n_fe;
    rx = 1'b0;
    repeat (4) @(negedge clk);
    chk("glitch_busy_hi", 32'(busy), 32'd1);
    rx = 1'b1;
    repeat (10) @(negedge clk);
    chk("glitch_busy_lo", 32'(busy), 32'd0);
    idle(2 * CPB);
    chk("glitch_no_sv", 32'(n_sv), 32'(sv0));
    chk("glitch_no_fe", 32'(n_fe), 32'(fe0));

    // Pending low byte, bad stop bit (clears pending), then a clean pair
    fe0 = n_fe;
    send_byte(8'h99, 1'b1);
    send_byte(8'h55, 1'b0);
    idle(2 * CPB);
    chk("ferr_count", 32'(n_fe), 32'(fe0 + 1));
    send_sample(16'h1234);
    idle(2 * CPB);
    chk("ferr_queue_empty", 32'(exp_q.size()), 32'd0);

    // Orphan low byte dropped by the idle gap timeout
    sv0 = n_sv;
    send_byte(8'hAA, 1'b1);
    idle(GAP + 10);
    chk("gap_no_sv", 32'(n_sv), 32'(sv0));
    send_sample(16'hABCD);
    idle(2 * CPB);
    chk("gap_one_sv", 32'(n_sv), 32'(sv0 + 1));
    chk("gap_queue_empty", 32'(exp_q.size()), 32'd0);

    // Reset mid-byte aborts it and also forgets a pending low byte
    send_sample(16'h1234);
    send_byte(8'h11, 1'b1);
    sv0 = n_sv;
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx = (i % 2 == 0);
      repeat (CPB) @(negedge clk);
    end
    repeat (CPB / 2) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("midrst_data_out", 32'(data_out), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_sv", 32'(sample_valid), 32'd0);
    rst = 1'b0;
    idle(2 * CPB);
    chk("midrst_no_sv", 32'(n_sv), 32'(sv0));
    send_sample(16'h5678);
    idle(2 * CPB);
    chk("midrst_after", 32'(data_out), 32'h5678);
    chk("midrst_queue_empty", 32'(exp_q.size()), 32'd0);

    // 100 random samples, bytes back to back with no idle
    sv0 = n_sv;
    fe0 = n_fe;
    for (int i = 0; i < 100; i++) begin
      r = 16'($urandom);
      send_sample(r);
    end
    idle(2 * CPB);
    chk("rand_sv_count", 32'(n_sv), 32'(sv0 + 100));
    chk("rand_no_fe", 32'(n_fe), 32'(fe0));
    chk("rand_queue_empty", 32'(exp_q.size()), 32'd0);
    chk("rand_hold", 32'(data_out), 32'(r));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
